hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_if.sv | 49 ++++
 rtl/hazard_ctrl.sv | 172 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if
//   Bundles the pipeline-status inputs and control outputs of the hazard
//   controller. The clock and reset are not part of the bundle.
//   master : the pipeline side; drives the status inputs, receives controls.
//   slave  : the hazard controller; reads the status, drives the controls.
//   Signals:
//     i_id_ex_MemRead, i_id_ex_Rd             - load in EX and its destination
//     i_if_id_Rs1/Rs2, i_if_id_use_rs1/rs2    - ID sources and whether they are read
//     i_ex_branch_taken                       - taken branch/jump resolved in EX
//     i_dmem_req, i_dmem_ready                - MEM access pending / completed
//     o_pc_write, o_if_id_write               - PC and IF/ID load enables
//     o_id_ex_bubble, o_if_id_flush           - NOP into ID/EX, clear IF/ID
//     o_pipe_hold                             - freeze ID/EX, EX/MEM, MEM/WB
//     o_mem_err                               - one-cycle data-memory timeout pulse
//     o_stall_cnt                             - saturating count of PC-frozen cycles
interface hazard_ctrl_if;
  logic        i_id_ex_MemRead;
  logic [4:0]  i_id_ex_Rd;
  logic [4:0]  i_if_id_Rs1;
  logic [4:0]  i_if_id_Rs2;
  logic        i_if_id_use_rs1;
  logic        i_if_id_use_rs2;
  logic        i_ex_branch_taken;
  logic        i_dmem_req;
  logic        i_dmem_ready;
  logic        o_pc_write;
  logic        o_if_id_write;
  logic        o_id_ex_bubble;
  logic        o_if_id_flush;
  logic        o_pipe_hold;
  logic        o_mem_err;
  logic [15:0] o_stall_cnt;

  modport master (
    output i_id_ex_MemRead, i_id_ex_Rd, i_if_id_Rs1, i_if_id_Rs2,
           i_if_id_use_rs1, i_if_id_use_rs2, i_ex_branch_taken,
           i_dmem_req, i_dmem_ready,
    input  o_pc_write, o_if_id_write, o_id_ex_bubble, o_if_id_flush,
           o_pipe_hold, o_mem_err, o_stall_cnt
  );

  modport slave (
    input  i_id_ex_MemRead, i_id_ex_Rd, i_if_id_Rs1, i_if_id_Rs2,
           i_if_id_use_rs1, i_if_id_use_rs2, i_ex_branch_taken,
           i_dmem_req, i_dmem_ready,
    output o_pc_write, o_if_id_write, o_id_ex_bubble, o_if_id_flush,
           o_pipe_hold, o_mem_err, o_stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Pipeline hazard controller: load-use stall, taken-branch flush and
//   data-memory wait with timeout, plus a saturating stall-cycle counter.
//   Parameters:
//     FLUSH_CYCLES (1..7) - cycles o_if_id_flush stays high after a taken branch
//     MEM_TIMEOUT  (2..15)- wait-counter value at which a memory wait is abandoned
//   Ports:
//     i_clk   - clock, rising edge
//     i_reset - asynchronous active-high reset; forces every output low
//     hz      - hazard_ctrl_if.slave bundle (status in, controls out)
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 15
) (
  input  logic          i_clk,
  input  logic          i_reset,
  hazard_ctrl_if.slave  hz
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_MEMW  = 2'd2
  } state_t;

  localparam logic [2:0] FLUSH_INIT  = 3'(FLUSH_CYCLES - 1);
  localparam logic [3:0] TIMEOUT_CNT = 4'(MEM_TIMEOUT);
  localparam bit         FLUSH_MULTI = (FLUSH_CYCLES > 1);

  state_t      state_q, state_d;
  logic [2:0]  flush_cnt_q, flush_cnt_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic mem_wait;
  logic load_use;

  // Outcome of a RUN-state evaluation that ignores the mem-wait condition.
  // Shared by RUN (when no mem-wait) and by MEMW in the cycle ready rises.
  logic   run_pc_write, run_if_id_write, run_bubble, run_flush;
  state_t run_state;
  logic [2:0] run_flush_cnt;

  // Internal (un-gated) control outputs.
  logic pc_write, if_id_write, bubble, flush, hold, mem_err;

  assign mem_wait = hz.i_dmem_req & ~hz.i_dmem_ready;

  // Writes to x0 never create a dependency; unused sources are ignored.
  assign load_use = hz.i_id_ex_MemRead && (hz.i_id_ex_Rd != 5'd0) &&
                    ((hz.i_if_id_use_rs1 && (hz.i_id_ex_Rd == hz.i_if_id_Rs1)) ||
                     (hz.i_if_id_use_rs2 && (hz.i_id_ex_Rd == hz.i_if_id_Rs2)));

  always_comb begin
    run_pc_write    = 1'b1;
    run_if_id_write = 1'b1;
    run_bubble      = 1'b0;
    run_flush       = 1'b0;
    run_state       = ST_RUN;
    run_flush_cnt   = 3'd0;
    if (hz.i_ex_branch_taken) begin
      run_flush  = 1'b1;
      run_bubble = 1'b1;
      if (FLUSH_MULTI) begin
        run_state     = ST_FLUSH;
        run_flush_cnt = FLUSH_INIT;
      end
    end else if (load_use) begin
      run_pc_write    = 1'b0;
      run_if_id_write = 1'b0;
      run_bubble      = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    bubble      = 1'b0;
    flush       = 1'b0;
    hold        = 1'b0;
    mem_err     = 1'b0;

    unique case (state_q)
      ST_RUN, ST_FLUSH: begin
        if (mem_wait) begin
          // Entering a memory wait discards any remaining flush count.
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          hold        = 1'b1;
          state_d     = ST_MEMW;
          wait_cnt_d  = 4'd1;
          flush_cnt_d = 3'd0;
        end else if (state_q == ST_RUN) begin
          pc_write    = run_pc_write;
          if_id_write = run_if_id_write;
          bubble      = run_bubble;
          flush       = run_flush;
          state_d     = run_state;
          flush_cnt_d = run_flush_cnt;
          wait_cnt_d  = 4'd0;
        end else begin
          flush = 1'b1;
          if (flush_cnt_q <= 3'd1) begin
            state_d     = ST_RUN;
            flush_cnt_d = 3'd0;
          end else begin
            flush_cnt_d = flush_cnt_q - 3'd1;
          end
        end
      end
      ST_MEMW: begin
        if (hz.i_dmem_ready) begin
          pc_write    = run_pc_write;
          if_id_write = run_if_id_write;
          bubble      = run_bubble;
          flush       = run_flush;
          state_d     = run_state;
          flush_cnt_d = run_flush_cnt;
          wait_cnt_d  = 4'd0;
        end else if (wait_cnt_q == TIMEOUT_CNT) begin
          // Give up: report once and let the pipeline run again.
          mem_err    = 1'b1;
          state_d    = ST_RUN;
          wait_cnt_d = 4'd0;
        end else begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          hold        = 1'b1;
          wait_cnt_d  = wait_cnt_q + 4'd1;
        end
      end
      default: begin
        state_d     = ST_RUN;
        flush_cnt_d = 3'd0;
        wait_cnt_d  = 4'd0;
      end
    endcase

    stall_cnt_d = stall_cnt_q;
    if (!pc_write && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= 3'd0;
      wait_cnt_q  <= 4'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Controls are combinational, so reset has to mask them directly to take
  // effect without waiting for a clock edge.
  assign hz.o_pc_write     = pc_write    & ~i_reset;
  assign hz.o_if_id_write  = if_id_write & ~i_reset;
  assign hz.o_id_ex_bubble = bubble      & ~i_reset;
  assign hz.o_if_id_flush  = flush       & ~i_reset;
  assign hz.o_pipe_hold    = hold        & ~i_reset;
  assign hz.o_mem_err      = mem_err     & ~i_reset;
  assign hz.o_stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
//   Directed vectors for hazard_ctrl (FLUSH_CYCLES=2, MEM_TIMEOUT=4).
//   The driver applies one vector per cycle and queues the expected
//   outputs; the monitor pops and compares on each falling edge.
//   Expected output order: {pc_write, if_id_write, bubble, flush, hold, mem_err}.
module tb_hazard_ctrl;

  logic clk;
  logic rst;

  hazard_ctrl_if hz ();

  hazard_ctrl #(
    .FLUSH_CYCLES (2),
    .MEM_TIMEOUT  (4)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .hz      (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [5:0]  outs;
    logic [15:0] stall;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_stall = 16'd0;

  // Apply one vector at posedge+1 and queue its expected response.
  task automatic drv(input string name, input bit r,
                     input bit mr, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input bit u1, input bit u2,
                     input bit br, input bit req, input bit rdy,
                     input logic [5:0] outs);
    exp_t e;
    @(posedge clk);
    #1;
    rst                  = r;
    hz.i_id_ex_MemRead   = mr;
    hz.i_id_ex_Rd        = rd;
    hz.i_if_id_Rs1       = rs1;
    hz.i_if_id_Rs2       = rs2;
    hz.i_if_id_use_rs1   = u1;
    hz.i_if_id_use_rs2   = u2;
    hz.i_ex_branch_taken = br;
    hz.i_dmem_req        = req;
    hz.i_dmem_ready      = rdy;
    if (r) exp_stall = 16'd0;
    e.name  = name;
    e.outs  = outs;
    e.stall = exp_stall;
    exp_q.push_back(e);
    // Counter advances at the edge closing this cycle if the PC was frozen.
    if (!r && !outs[5] && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
  endtask

  task automatic idle(input string name, input logic [5:0] outs);
    drv(name, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, outs);
  endtask

  task automatic memv(input string name, input bit br, input bit req,
                      input bit rdy, input logic [5:0] outs);
    drv(name, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, br, req, rdy, outs);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t       e;
      logic [5:0] act;
      e   = exp_q.pop_front();
      act = {hz.o_pc_write, hz.o_if_id_write, hz.o_id_ex_bubble,
             hz.o_if_id_flush, hz.o_pipe_hold, hz.o_mem_err};
      n_checks++;
      if (act !== e.outs || hz.o_stall_cnt !== e.stall) begin
        n_fail++;
        $display("FAIL %s: got outs=%b stall=%0d, expected outs=%b stall=%0d",
                 e.name, act, hz.o_stall_cnt, e.outs, e.stall);
      end else begin
        $display("ok   %s: outs=%b stall=%0d", e.name, act, hz.o_stall_cnt);
      end
    end
  end

  initial begin
    rst                  = 1'b1;
    hz.i_id_ex_MemRead   = 1'b0;
    hz.i_id_ex_Rd        = 5'd0;
    hz.i_if_id_Rs1       = 5'd0;
    hz.i_if_id_Rs2       = 5'd0;
    hz.i_if_id_use_rs1   = 1'b0;
    hz.i_if_id_use_rs2   = 1'b0;
    hz.i_ex_branch_taken = 1'b0;
    hz.i_dmem_req        = 1'b0;
    hz.i_dmem_ready      = 1'b0;

    //   name             r  mr rd     rs1    rs2    u1 u2 br rq rdy  outs
    drv("reset",          1, 0, 5'd0, 5'd0, 5'd0,  0, 0, 0, 0, 0, 6'b000000);
    idle("run_default",                                            6'b110000);
    drv("load_use_rs1",   0, 1, 5'd5, 5'd5, 5'd0,  1, 0, 0, 0, 0, 6'b001000);
    idle("after_load_use",                                         6'b110000);
    drv("x0_no_stall",    0, 1, 5'd0, 5'd0, 5'd0,  1, 0, 0, 0, 0, 6'b110000);
    drv("rs2_unused",     0, 1, 5'd7, 5'd3, 5'd7,  1, 0, 0, 0, 0, 6'b110000);
    drv("load_use_rs2",   0, 1, 5'd9, 5'd3, 5'd9,  0, 1, 0, 0, 0, 6'b001000);

    memv("branch",        1, 0, 0, 6'b111100);
    memv("flush_2nd",     0, 0, 0, 6'b110100);
    idle("after_flush",            6'b110000);

    memv("memwait_1",     0, 1, 0, 6'b000010);
    memv("memwait_2_br",  1, 1, 0, 6'b000010);
    memv("memwait_3",     0, 1, 0, 6'b000010);
    memv("mem_ready",     0, 1, 1, 6'b110000);
    idle("after_mem",              6'b110000);

    memv("tmo_1",         0, 1, 0, 6'b000010);
    memv("tmo_2",         0, 1, 0, 6'b000010);
    memv("tmo_3",         0, 1, 0, 6'b000010);
    memv("tmo_4",         0, 1, 0, 6'b000010);
    memv("tmo_err",       0, 1, 0, 6'b110001);
    idle("after_tmo",              6'b110000);

    drv("all_hazards",    0, 1, 5'd5, 5'd5, 5'd0,  1, 0, 1, 1, 0, 6'b000010);
    drv("all_hazards_mw", 0, 1, 5'd5, 5'd5, 5'd0,  1, 0, 1, 1, 0, 6'b000010);
    drv("reset_in_memw",  1, 1, 5'd5, 5'd5, 5'd0,  1, 0, 1, 1, 0, 6'b000000);
    idle("post_reset_run",         6'b110000);

    memv("branch_b",      1, 0, 0, 6'b111100);
    drv("reset_in_flush", 1, 0, 5'd0, 5'd0, 5'd0,  0, 0, 0, 0, 0, 6'b000000);
    idle("post_reset_run2",        6'b110000);

    memv("memwait_c",     0, 1, 0, 6'b000010);
    memv("ready_branch",  1, 1, 1, 6'b111100);
    memv("flush_after_mw",0, 0, 0, 6'b110100);
    idle("after_flush_c",          6'b110000);

    memv("branch_d",      1, 0, 0, 6'b111100);
    memv("flush_memwait", 0, 1, 0, 6'b000010);
    memv("ready_no_flush",0, 1, 1, 6'b110000);
    idle("final_idle",             6'b110000);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending responses, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
